// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Brief    : Shared constants and the digit-to-segment table for ssd_scanner.
// Revision : 1.0
// ============================================================================
package ssd_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [11:0] SLOT_INVALID = 12'hFFF;

    localparam logic [1:0] POS_IDX = 2'd3;
    localparam logic [1:0] POS_HUN = 2'd2;
    localparam logic [1:0] POS_TEN = 2'd1;
    localparam logic [1:0] POS_ONE = 2'd0;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg
// Brief    : BCD nibble plus blank flag to active-low seven-segment pattern.
// Revision : 1.0
// ============================================================================
module bcd_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Non-decimal nibbles fall through to the blank pattern in the table
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            o_seg = digit_to_seg(i_digit);
        end
    end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/ssd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scanner
// Brief    : Four-digit multiplexed seven-segment driver with slot selection.
// Revision : 1.0
// ============================================================================
module ssd_scanner
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] numbers,
    input  logic        next,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  sel_idx
);

    localparam int              c_PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic [1:0]           r_pos;
    logic [1:0]           r_sel;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic [11:0] w_slot [4];
    logic [3:0]  w_valid;
    logic        w_any_valid;
    logic        w_tick;
    logic        w_adv;
    logic        w_found;
    logic [1:0]  w_next_sel;
    logic [1:0]  w_c1, w_c2, w_c3;
    logic [11:0] w_cur;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_seg;

    for (genvar k = 0; k < 4; k++) begin : g_slot
        assign w_slot[k]  = numbers[12*k +: 12];
        assign w_valid[k] = (w_slot[k] != SLOT_INVALID);
    end

    assign w_any_valid = |w_valid;
    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_cur       = w_slot[r_sel];

    // Auto-advance only when there is somewhere valid to move to
    assign w_adv = next | (~w_valid[r_sel] & w_any_valid);

    assign w_c1 = r_sel + 2'd1;
    assign w_c2 = r_sel + 2'd2;
    assign w_c3 = r_sel + 2'd3;

    always_comb begin
        w_found    = 1'b1;
        w_next_sel = r_sel;
        if (w_valid[w_c1]) begin
            w_next_sel = w_c1;
        end else if (w_valid[w_c2]) begin
            w_next_sel = w_c2;
        end else if (w_valid[w_c3]) begin
            w_next_sel = w_c3;
        end else begin
            w_found = 1'b0;
        end
    end

    // Leading-zero suppression: tens only blanks when hundreds is also zero
    always_comb begin
        w_digit = w_cur[3:0];
        w_blank = 1'b0;
        case (r_pos)
            POS_IDX: w_digit = {2'b00, r_sel} + 4'd1;
            POS_HUN: begin
                w_digit = w_cur[11:8];
                w_blank = (w_cur[11:8] == 4'd0);
            end
            POS_TEN: begin
                w_digit = w_cur[7:4];
                w_blank = (w_cur[11:8] == 4'd0) && (w_cur[7:4] == 4'd0);
            end
            default: w_digit = w_cur[3:0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_pos   <= POS_ONE;
            r_sel   <= 2'd0;
            r_an    <= 4'hF;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
            if (w_tick) begin
                r_pos <= r_pos + 2'd1;
            end
            if (w_adv && w_found) begin
                r_sel <= w_next_sel;
            end
            if (w_any_valid) begin
                r_an  <= ~(4'b0001 << r_pos);
                r_seg <= w_seg;
                r_dp  <= (r_pos != POS_IDX);
            end else begin
                r_an  <= 4'hF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign sel_idx = r_sel;

endmodule : ssd_scanner
`default_nettype wire

// File: tb/tb_ssd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scanner
// Brief    : Self-checking bench for ssd_scanner against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_ssd_scanner;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next = 1'b0;
    logic [47:0] numbers = '1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  sel_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ssd_scanner #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .reset   (reset),
        .numbers (numbers),
        .next    (next),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .sel_idx (sel_idx)
    );

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    function automatic logic [11:0] slot_of(input logic [47:0] n, input int k);
        return n[12*k +: 12];
    endfunction

    function automatic bit any_valid(input logic [47:0] n);
        for (int k = 0; k < 4; k++) if (slot_of(n, k) != 12'hFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Returns {an, seg, dp} for a digit position, selection and slot bus
    function automatic logic [11:0] disp(input int pos, input logic [1:0] sel, input logic [47:0] n);
        logic [11:0] s;
        int h, t, o, d;
        bit blank;
        logic [3:0] a;
        logic [6:0] sg;
        if (!any_valid(n)) return {4'hF, 7'h7F, 1'b1};
        s = slot_of(n, int'(sel));
        h = int'(s[11:8]);
        t = int'(s[7:4]);
        o = int'(s[3:0]);
        a = 4'hF;
        a[pos] = 1'b0;
        blank = 1'b0;
        case (pos)
            3: d = int'(sel) + 1;
            2: begin d = h; blank = (h == 0); end
            1: begin d = t; blank = (h == 0 && t == 0); end
            default: d = o;
        endcase
        sg = (blank || d > 9) ? 7'h7F : seg_tbl[d];
        return {a, sg, (pos == 3) ? 1'b0 : 1'b1};
    endfunction

    function automatic logic [1:0] next_sel(input logic [1:0] sel, input logic [47:0] n, input logic nx);
        int c;
        bit adv;
        adv = nx || (slot_of(n, int'(sel)) == 12'hFFF && any_valid(n));
        if (adv) begin
            for (int i = 1; i <= 3; i++) begin
                c = (int'(sel) + i) % 4;
                if (slot_of(n, c) != 12'hFFF) return 2'(c);
            end
        end
        return sel;
    endfunction

    // Model: position follows directly from the count of edges since reset
    int         m_t = 0;
    logic [1:0] m_sel = 2'd0;
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg = 7'h7F;
    logic       m_dp = 1'b1;
    bit         m_init = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_t    <= 0;
            m_sel  <= 2'd0;
            m_an   <= 4'hF;
            m_seg  <= 7'h7F;
            m_dp   <= 1'b1;
            m_init <= 1'b1;
        end else begin
            m_t <= m_t + 1;
            {m_an, m_seg, m_dp} <= disp((m_t / SD) % 4, m_sel, numbers);
            m_sel <= next_sel(m_sel, numbers, next);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            n_vec++;
            if (an !== m_an || seg !== m_seg || dp !== m_dp || sel_idx !== m_sel) begin
                n_err++;
                $display("FAIL model t=%0t: got an=%b seg=%b dp=%b sel=%0d, required an=%b seg=%b dp=%b sel=%0d",
                         $time, an, seg, dp, sel_idx, m_an, m_seg, m_dp, m_sel);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_next();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    // Waits for a fresh entry into anode pattern tgt, then checks it and its hold time
    task automatic wait_an(input logic [3:0] tgt, input logic [6:0] s, input logic d, input string nm);
        int k;
        bit ok;
        ok = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (an !== tgt) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            ok = 1'b0;
            for (k = 0; k < 40; k++) begin
                if (an === tgt) begin ok = 1'b1; break; end
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: an=%b, required %b", nm, an, tgt);
            return;
        end
        lit({nm, " seg"}, 32'(seg), 32'(s));
        lit({nm, " dp"}, 32'(dp), 32'(d));
        k = 0;
        while (an === tgt && k < 20) begin
            k++;
            @(negedge clk);
        end
        lit({nm, " hold"}, 32'(k), 32'(SD));
    endtask

    initial begin
        int r;
        // Reset
        numbers = '1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset an", 32'(an), 32'hF);
        lit("reset seg", 32'(seg), 32'h7F);
        lit("reset dp", 32'(dp), 32'h1);
        lit("reset sel", 32'(sel_idx), 32'h0);

        // Single valid slot, first-tick timing
        numbers = {36'hFFFFFFFFF, 12'h024};
        reset = 1'b0;
        @(negedge clk);
        lit("pos0 first an", 32'(an), 32'b1110);
        lit("pos0 first seg", 32'(seg), 32'b0011001);
        repeat (3) @(negedge clk);
        lit("pos0 pre-tick an", 32'(an), 32'b1110);
        @(negedge clk);
        lit("first tick an", 32'(an), 32'b1101);
        wait_an(4'b0111, 7'b1111001, 1'b0, "s0 pos3");
        wait_an(4'b1011, 7'h7F,      1'b1, "s0 pos2");
        wait_an(4'b1101, 7'b0100100, 1'b1, "s0 pos1");
        wait_an(4'b1110, 7'b0011001, 1'b1, "s0 pos0");

        // Slot skipping and embedded zero
        numbers = {12'h105, 12'hFFF, 12'hFFF, 12'h007};
        @(negedge clk);
        pulse_next();
        lit("skip sel", 32'(sel_idx), 32'd3);
        wait_an(4'b1011, 7'b1111001, 1'b1, "s3 pos2");
        wait_an(4'b1101, 7'b1000000, 1'b1, "s3 pos1");
        wait_an(4'b1110, 7'b0010010, 1'b1, "s3 pos0");
        wait_an(4'b0111, 7'b0011001, 1'b0, "s3 pos3");
        pulse_next();
        lit("wrap sel", 32'(sel_idx), 32'd0);

        // All slots invalid
        numbers = '1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            lit("invalid an", 32'(an), 32'hF);
            next = (i == 10 || i == 25);
            @(negedge clk);
        end
        next = 1'b0;
        lit("invalid sel", 32'(sel_idx), 32'd0);

        // Auto-advance, then auto-advance coinciding with next
        numbers = {12'hFFF, 12'h024, 12'hFFF, 12'h007};
        @(negedge clk);
        lit("auto pre sel", 32'(sel_idx), 32'd0);
        numbers[11:0] = 12'hFFF;
        @(negedge clk);
        lit("auto sel", 32'(sel_idx), 32'd2);
        numbers[11:0] = 12'h007;
        @(negedge clk);
        pulse_next();
        lit("back sel", 32'(sel_idx), 32'd0);
        numbers = {12'h033, 12'h024, 12'hFFF, 12'hFFF};
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        lit("auto+next sel", 32'(sel_idx), 32'd2);

        // Reset mid-scan at position 2 with slot 3 selected
        pulse_next();
        lit("pre-reset sel", 32'(sel_idx), 32'd3);
        for (int i = 0; i < 40 && an !== 4'b1011; i++) @(negedge clk);
        lit("pre-reset an", 32'(an), 32'b1011);
        reset = 1'b1;
        @(negedge clk);
        lit("midreset an", 32'(an), 32'hF);
        lit("midreset seg", 32'(seg), 32'h7F);
        lit("midreset dp", 32'(dp), 32'h1);
        lit("midreset sel", 32'(sel_idx), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        lit("resume an", 32'(an), 32'b1110);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 3));
                numbers[12*r +: 12] = ($urandom_range(0, 2) == 0) ? 12'hFFF :
                    (($urandom_range(0, 3) == 0) ? 12'($urandom) :
                     {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            end
            next  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        next  = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ssd_scanner
`default_nettype wire
